// File: rtl/lc3b_ctrl_pkg.sv
// Shared constants for the LC-3b control path.
// Contents:
//   state_e  - 6-bit microstate IDs, as decoded by the control store
//   OP_*     - IR[15:12] opcode values the microsequencer dispatches on
package lc3b_ctrl_pkg;

    typedef enum logic [5:0] {
        S_BR        = 6'd0,
        S_ADD       = 6'd1,
        S_AND       = 6'd5,
        S_XOR       = 6'd9,
        S_JMP       = 6'd12,
        S_LEA       = 6'd14,
        S_FETCH_MAR = 6'd18,
        S_FETCH_PC  = 6'd19,
        S_BR_TAKEN  = 6'd22,
        S_DECODE    = 6'd32,
        S_FETCH_MEM = 6'd33,
        S_FETCH_IR  = 6'd35,
        S_HALT      = 6'd63
    } state_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

endpackage

// File: rtl/lc3b_wait_timer.sv
// Memory-wait timer for the instruction fetch.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (asserted on the cycle before entering the wait state)
//   enable    - high while the sequencer sits in the wait state
//   ready     - memory read complete
//   expired   - this is the last allowed wait cycle and memory is still not ready
module lc3b_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MEM_TIMEOUT);

    // Number of wait cycles already completed; during wait cycle n it holds n-1.
    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !ready && r_count != MAX_COUNT) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A ready on the final cycle wins over the timeout.
    assign expired = enable && !ready && (r_count == LAST_WAIT);

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: state register and next-state logic for the control path.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   run          - allow a new fetch to start from state 18
//   ir_opcode    - IR[15:12], meaningful from state 32 onward
//   ben          - branch enable, used only in state 0
//   mem_ready    - memory read complete, used only in state 33
//   state_id     - current microstate to the control store
//   mem_req      - high while in state 33
//   halted       - high while in S_HALT
//   err_illegal  - sticky: halted on an unsupported opcode or an undefined state
//   err_timeout  - sticky: halted because memory never became ready
//   instr_count  - retired instructions, wraps modulo 2^CNT_W
module lc3b_microsequencer
    import lc3b_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       ir_opcode,
    input  logic             ben,
    input  logic             mem_ready,
    output logic [5:0]       state_id,
    output logic             mem_req,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] instr_count
);

    state_e             r_state;
    logic               r_mem_req;
    logic               r_halted;
    logic               r_err_illegal;
    logic               r_err_timeout;
    logic [CNT_W-1:0]   r_instr_count;

    state_e w_next;
    logic   w_retire;
    logic   w_set_illegal;
    logic   w_set_timeout;
    logic   w_expired;

    // The counter is cleared from state 19, the only way into state 33.
    lc3b_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == S_FETCH_PC),
        .enable  (r_state == S_FETCH_MEM),
        .ready   (mem_ready),
        .expired (w_expired)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_FETCH_MAR: if (run) w_next = S_FETCH_PC;
            S_FETCH_PC:  w_next = S_FETCH_MEM;
            S_FETCH_MEM: begin
                if (mem_ready) begin
                    w_next = S_FETCH_IR;
                end else if (w_expired) begin
                    w_next        = S_HALT;
                    w_set_timeout = 1'b1;
                end
            end
            S_FETCH_IR:  w_next = S_DECODE;
            S_DECODE: begin
                case (ir_opcode)
                    OP_BR:   w_next = S_BR;
                    OP_ADD:  w_next = S_ADD;
                    OP_AND:  w_next = S_AND;
                    OP_XOR:  w_next = S_XOR;
                    OP_JMP:  w_next = S_JMP;
                    OP_LEA:  w_next = S_LEA;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_BR: begin
                if (ben) begin
                    w_next = S_BR_TAKEN;
                end else begin
                    w_next   = S_FETCH_MAR;
                    w_retire = 1'b1;
                end
            end
            S_ADD, S_AND, S_XOR, S_JMP, S_LEA, S_BR_TAKEN: begin
                w_next   = S_FETCH_MAR;
                w_retire = 1'b1;
            end
            S_HALT:      w_next = S_HALT;
            default: begin
                w_next        = S_HALT;
                w_set_illegal = 1'b1;
            end
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH_MAR;
            r_mem_req     <= 1'b0;
            r_halted      <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state   <= w_next;
            r_mem_req <= (w_next == S_FETCH_MEM);
            r_halted  <= (w_next == S_HALT);
            if (w_set_illegal) r_err_illegal <= 1'b1;
            if (w_set_timeout) r_err_timeout <= 1'b1;
            if (w_retire)      r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign state_id    = r_state;
    assign mem_req     = r_mem_req;
    assign halted      = r_halted;
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_lc3b_microsequencer.sv
module tb_lc3b_microsequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [3:0]       ir_opcode;
    logic             ben;
    logic             mem_ready;
    logic [5:0]       state_id;
    logic             mem_req;
    logic             halted;
    logic             err_illegal;
    logic             err_timeout;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       run;
        logic       mem_ready;
        logic [3:0] opcode;
        logic       ben;
        int         exp_state;
        int         exp_count;
    } vec_t;

    vec_t vecs[$];

    lc3b_microsequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .ir_opcode   (ir_opcode),
        .ben         (ben),
        .mem_ready   (mem_ready),
        .state_id    (state_id),
        .mem_req     (mem_req),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input int st, input int mreq, input int hlt,
                               input int ill, input int tmo, input int cnt);
        check({name, " state"},       0, int'(state_id),    st);
        check({name, " mem_req"},     0, int'(mem_req),     mreq);
        check({name, " halted"},      0, int'(halted),      hlt);
        check({name, " err_illegal"}, 0, int'(err_illegal), ill);
        check({name, " err_timeout"}, 0, int'(err_timeout), tmo);
        check({name, " instr_count"}, 0, int'(instr_count), cnt);
    endtask

    task automatic push(input logic r, input logic rdy, input logic [3:0] op, input logic b,
                        input int st, input int cnt);
        vec_t v;
        v.run = r; v.mem_ready = rdy; v.opcode = op; v.ben = b;
        v.exp_state = st; v.exp_count = cnt;
        vecs.push_back(v);
    endtask

    // Zero-wait instruction: 18 -> 19 -> 33 -> 35 -> 32 -> exec [-> 22] -> 18.
    task automatic push_instr(input logic [3:0] op, input int exec_st, input logic b,
                              input int cnt_before);
        push(1'b1, 1'b1, op, b, 19, cnt_before);
        push(1'b1, 1'b1, op, b, 33, cnt_before);
        push(1'b1, 1'b1, op, b, 35, cnt_before);
        push(1'b1, 1'b1, op, b, 32, cnt_before);
        push(1'b1, 1'b1, op, b, exec_st, cnt_before);
        if (exec_st == 0 && b) push(1'b1, 1'b1, op, b, 22, cnt_before);
        push(1'b1, 1'b1, op, b, 18, (cnt_before + 1) % 16);
    endtask

    // Runs one zero-wait instruction, bounded so a stuck DUT cannot hang the bench.
    task automatic do_instr(input logic [3:0] op, input logic b);
        int k;
        run = 1'b1; mem_ready = 1'b1; ir_opcode = op; ben = b;
        step();
        k = 1;
        while (state_id != 6'd18 && k < 12) begin
            step();
            k++;
        end
        check("instr return to 18", k, int'(state_id), 18);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; ir_opcode = OP_ADD; ben = 1'b0; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_flags("reset", 18, 0, 0, 0, 0, 0);

        // Table: zero-wait instructions of every supported opcode plus a run stall.
        push_instr(OP_ADD, 1,  1'b0, 0);
        push_instr(OP_BR,  0,  1'b0, 1);
        push_instr(OP_BR,  0,  1'b1, 2);
        push(1'b0, 1'b1, OP_ADD, 1'b0, 18, 3);
        push(1'b0, 1'b1, OP_ADD, 1'b0, 18, 3);
        push(1'b0, 1'b1, OP_ADD, 1'b0, 18, 3);
        push_instr(OP_AND, 5,  1'b0, 3);
        push_instr(OP_XOR, 9,  1'b1, 4);
        push_instr(OP_JMP, 12, 1'b0, 5);
        push_instr(OP_LEA, 14, 1'b0, 6);

        for (int i = 0; i < vecs.size(); i++) begin
            run = vecs[i].run; mem_ready = vecs[i].mem_ready;
            ir_opcode = vecs[i].opcode; ben = vecs[i].ben;
            step();
            check("vec state",   i, int'(state_id),    vecs[i].exp_state);
            check("vec mem_req", i, int'(mem_req),     int'(vecs[i].exp_state == 33));
            check("vec count",   i, int'(instr_count), vecs[i].exp_count);
        end

        // Memory ready on the 4th cycle in 33.
        run = 1'b1; mem_ready = 1'b0; ir_opcode = OP_ADD; ben = 1'b0;
        step();
        step();
        check("wait4 enter", 0, int'(state_id), 33);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("wait4 hold", k, int'(state_id), 33);
            check("wait4 mem_req", k, int'(mem_req), 1);
        end
        mem_ready = 1'b1;
        step();
        check_flags("wait4 exit", 35, 0, 0, 0, 0, 7);
        step();
        step();
        step();
        check("wait4 retire", 0, int'(state_id), 18);
        check("wait4 count", 0, int'(instr_count), 8);

        // Ready on the very last allowed cycle wins over the timeout.
        mem_ready = 1'b0;
        step();
        step();
        for (int k = 1; k < MEM_TIMEOUT; k++) step();
        check("wait15 hold", 0, int'(state_id), 33);
        mem_ready = 1'b1;
        step();
        check_flags("wait15 exit", 35, 0, 0, 0, 0, 8);
        step();
        step();
        step();
        check("wait15 count", 0, int'(instr_count), 9);

        // Reset in the middle of a memory wait.
        mem_ready = 1'b0;
        step();
        step();
        step();
        step();
        check("midwait state", 0, int'(state_id), 33);
        rst = 1'b1;
        step();
        check_flags("midwait reset", 18, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // run=0 stalls in 18 with no side effects.
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall state", k, int'(state_id), 18);
            check("stall count", k, int'(instr_count), 0);
        end

        // Illegal opcode after one retired instruction.
        do_instr(OP_ADD, 1'b0);
        ir_opcode = 4'b1111;
        for (int k = 0; k < 5; k++) step();
        check_flags("illegal", 63, 0, 1, 1, 0, 1);
        ir_opcode = OP_ADD;
        for (int k = 0; k < 4; k++) step();
        check_flags("illegal absorb", 63, 0, 1, 1, 0, 1);
        do_reset();
        check_flags("illegal reset", 18, 0, 0, 0, 0, 0);

        // Memory timeout.
        run = 1'b1; mem_ready = 1'b0; ir_opcode = OP_ADD;
        step();
        step();
        for (int k = 1; k < MEM_TIMEOUT; k++) step();
        check_flags("timeout last", 33, 1, 0, 0, 0, 0);
        step();
        check_flags("timeout", 63, 0, 1, 0, 1, 0);
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check_flags("timeout absorb", 63, 0, 1, 0, 1, 0);
        do_reset();
        check_flags("timeout reset", 18, 0, 0, 0, 0, 0);

        // Count wraps after 2^CNT_W retirements.
        for (int k = 1; k <= 16; k++) begin
            do_instr(OP_ADD, 1'b0);
            check("wrap count", k, int'(instr_count), k % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
